fetch_pc_unit: RTL and testbench



---
 rtl/cpu_fetch_pkg.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/fetch_pc_unit.sv | 133 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the fetch/PC stage.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int PC_STEP    = 4;
  localparam int R15_OFFSET = 4;
  localparam int INSTR_W    = 32;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts unacknowledged fetch cycles; expired marks the last allowed one.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Fires on the TIMEOUT-th consecutive waiting cycle itself.
  assign expired = en && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC + instruction fetch stage with imem handshake, redirects and stalls.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  r15_pc,
  output logic               fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               squash_q, squash_d;
  logic               take;
  logic               expired;
  logic               in_fetch;
  logic [ADDR_W-1:0]  tgt;

  assign tgt      = {branch_target[ADDR_W-1:2], 2'b00};
  assign in_fetch = (state_q == FETCH);

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_fetch || imem_ack),
    .en     (in_fetch && !imem_ack),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    squash_d = squash_q;
    take     = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (branch_valid) pc_d = tgt;
      end
      FETCH: begin
        if (expired) begin
          state_d = FAULT;
        end else if (imem_ack) begin
          squash_d = 1'b0;
          if (branch_valid) begin
            pc_d = tgt;
          end else if (!squash_q) begin
            instr_d = imem_rdata;
            state_d = ISSUE;
            take    = 1'b1;
          end
        end else if (branch_valid) begin
          // Old request still owes an ack; drop it when it lands.
          pc_d     = tgt;
          squash_d = 1'b1;
        end
      end
      ISSUE: begin
        if (branch_valid) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          state_d = FETCH;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      squash_q <= squash_d;
    end
  end

  assign imem_req    = in_fetch;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc          = pc_q;
  assign r15_pc      = pc_q + ADDR_W'(R15_OFFSET);
  assign fault       = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (take && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (state_q == ISSUE && stall && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a cycle-level reference model.
module tb_fetch_pc_unit;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] r15_pc;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  fetch_pc_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .r15_pc       (r15_pc),
    .fault        (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Model: phase 0 booting, 1 waiting on memory, 2 holding an instruction, 3 dead.
  int          m_phase;
  int          m_wait;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_fetched;
  int          m_stalls;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_wait = 0; m_drop = 0;
      m_pc = 32'h0; m_instr = 32'h0;
      m_fetched = 0; m_stalls = 0;
    end else begin
      case (m_phase)
        0: begin
          if (branch_valid) m_pc = branch_target & ~32'h3;
          m_phase = 1; m_wait = 0;
        end
        1: begin
          if (imem_ack) begin
            m_wait = 0;
            if (branch_valid) m_pc = branch_target & ~32'h3;
            else if (!m_drop) begin
              m_instr = imem_rdata; m_phase = 2; m_fetched++;
            end
            m_drop = 0;
          end else begin
            m_wait++;
            if (m_wait == TMO) m_phase = 3;
            else if (branch_valid) begin
              m_pc = branch_target & ~32'h3; m_drop = 1;
            end
          end
        end
        2: begin
          if (stall) m_stalls++;
          if (branch_valid) begin
            m_pc = branch_target & ~32'h3; m_phase = 1; m_wait = 0;
          end else if (!stall) begin
            m_pc = m_pc + 32'd4; m_phase = 1; m_wait = 0;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_phase >= 0) begin
      chk("imem_req", 32'(imem_req), 32'(m_phase == 1));
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
      chk("instr", instr, m_instr);
      chk("pc", pc, m_pc);
      chk("r15_pc", r15_pc, m_pc + 32'd4);
      chk("fault", 32'(fault), 32'(m_phase == 3));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, 32'(m_fetched));
      chk("perf_stall", perf_stall, 32'(m_stalls));
`endif
    end
  end

  task automatic cyc(input logic s, input logic b, input logic [31:0] t,
                     input logic a, input logic [31:0] d);
    stall = s; branch_valid = b; branch_target = t;
    imem_ack = a; imem_rdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_phase = -1;
    rst = 1'b0;
    stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_pc", pc, 32'h0);
    chk("lit_rst_r15", r15_pc, 32'h4);
    chk("lit_rst_req", 32'(imem_req), 32'h0);
    rst = 1'b0;

    // zero-wait memory
    idle();
    chk("lit_addr0", imem_addr, 32'h0);
    chk("lit_r15_0", r15_pc, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000);
    chk("lit_instr0", instr, 32'hA000_0000);
    idle();
    chk("lit_addr4", imem_addr, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0001);
    idle();
    chk("lit_addr8", imem_addr, 32'h8);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0002);

    // decode stall
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("lit_stall_pc", pc, 32'h8);
    chk("lit_stall_instr", instr, 32'hA000_0002);
    idle();
    chk("lit_addrC", imem_addr, 32'hC);

    // redirect while waiting; stale ack must be dropped
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("lit_redir_addr", imem_addr, 32'h100);
    idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
    chk("lit_drop_valid", 32'(instr_valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hD000_0001);
    chk("lit_after_drop", instr, 32'hD000_0001);

    // misaligned target from ISSUE
    cyc(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    chk("lit_align", imem_addr, 32'h100);

    // branch in the same cycle as ack
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'hBAD0_0002);
    chk("lit_sameack_valid", 32'(instr_valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hD000_0002);
    chk("lit_sameack_pc", pc, 32'h40);

    // branch beats stall, then wrap
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("lit_wrap_r15", r15_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hD000_0003);
    idle();
    chk("lit_wrap_addr", imem_addr, 32'h0);

    // timeout
    for (int i = 0; i < TMO - 1; i++) idle();
    chk("lit_tmo_pre", 32'(fault), 32'h0);
    idle();
    chk("lit_tmo_fault", 32'(fault), 32'h1);
    chk("lit_tmo_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h500, 1'b1, 32'h77);
    chk("lit_frozen_pc", pc, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_clr_fault", 32'(fault), 32'h0);
    rst = 1'b0;

    // reset in the middle of a fetch, ack arriving during BOOT
    idle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("lit_boot_ack_valid", 32'(instr_valid), 32'h0);
    chk("lit_boot_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("lit_perf_zero", perf_fetched, 32'h0);
`endif
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_1234);
    chk("lit_final_instr", instr, 32'h0000_1234);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
